adi2axis_pkt: RTL

Parametrised successor to the ADI-sample-to-AXI-Stream converter. It accepts the free-running ADI sample interface (`ddata`/`dvalid`/`dsync`) and frames it into AXI-Stream packets for the DMA. Framing is configurable: packet length, packet count, trigger mode and single-shot or continuous operation. A small FIFO absorbs DMA backpressure; overflow is counted rather than silently lost. It sits between the ADC/DMA interface core and the AXIS DMA, in the DMA clock domain.

---
 rtl/adi2axis_pkg.sv | 31 +++
 rtl/adi2axis_fifo.sv | 87 ++++++++
 rtl/adi2axis_pkt.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adi2axis_pkg.sv
// adi2axis_pkg
// Shared definitions for the ADI-sample-to-AXI-Stream packetiser:
//   - state_t      : framing FSM states
//   - CTRL_*       : bit positions inside the 32-bit ctrl word
//   - STAT_*       : LSB offsets of the fields inside the 32-bit stat word
//   - OVF_CNT_MAX  : saturation value of the overflow counter
package adi2axis_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int CTRL_ENABLE     = 0;
    localparam int CTRL_TRIG_MODE  = 1;
    localparam int CTRL_CONTINUOUS = 2;
    localparam int CTRL_OVF_CLR    = 3;

    localparam int STAT_BUSY       = 0;
    localparam int STAT_DONE       = 1;
    localparam int STAT_OVF_STICKY = 2;
    localparam int STAT_ABORTED    = 3;
    localparam int STAT_PKT_DONE   = 4;   // 12-bit field
    localparam int STAT_OVF_CNT    = 16;  // 16-bit field

    localparam logic [15:0] OVF_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/adi2axis_fifo.sv
// adi2axis_fifo
// Synchronous first-word-fall-through FIFO with a registered output word.
// The memory holds every stored entry; rd_data is a registered copy of the
// current head, so a word written into an empty FIFO is visible one cycle
// later. Total capacity is exactly DEPTH entries.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_en, wr_data    : push request (ignored when full unless a pop happens)
//   rd_en             : pop the head (ignored when empty)
//   rd_data           : head entry, valid while !empty
//   full, empty, count: occupancy status
module adi2axis_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] dout_reg;

    logic             wr_ok;
    logic             rd_ok;
    logic [AW-1:0]    rd_idx_next;
    logic [AW:0]      remaining;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == FULL_COUNT);
    assign count = count_reg;
    assign rd_data = dout_reg;

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // succeeds when it coincides with a pop.
    assign rd_ok = rd_en & ~empty;
    assign wr_ok = wr_en & (~full | rd_ok);

    assign rd_idx_next = rd_ptr_reg + {{(AW-1){1'b0}}, rd_ok};
    // Entries already in memory that survive this cycle's pop.
    assign remaining   = count_reg - {{AW{1'b0}}, rd_ok};

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
            // Next head comes from memory, or straight from the write port
            // when nothing older remains.
            if (remaining == '0) begin
                if (wr_ok) begin
                    dout_reg <= wr_data;
                end
            end else begin
                dout_reg <= mem[rd_idx_next];
            end
        end
    end

endmodule

// File: rtl/adi2axis_pkt.sv
// adi2axis_pkt
// Frames the free-running ADI sample stream into AXI-Stream packets.
// Ports:
//   AXIS_ACLK, AXIS_ARESETN : clock, asynchronous active-low reset
//   ddata, dvalid, dsync    : sample input, qualified by dvalid & dsync
//   M_AXIS_*                : AXI-Stream master (TKEEP all-ones while valid)
//   ctrl                    : enable / trig_mode / continuous / ovf_clr
//   pkt_bytes, pkt_count    : packet length in bytes, packets per run (0 = unlimited)
//   trig                    : external trigger, rising edge starts capture
//   ovf                     : one-cycle pulse per dropped sample
//   stat                    : {ovf_cnt, pkt_done_cnt, aborted, ovf_sticky, done, busy}
module adi2axis_pkt
    import adi2axis_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_NUM_BYTES = 8,
    parameter int FIFO_DEPTH               = 16
) (
    input  logic                                  AXIS_ACLK,
    input  logic                                  AXIS_ARESETN,
    input  logic [8*C_M_AXIS_TDATA_NUM_BYTES-1:0] ddata,
    input  logic                                  dvalid,
    input  logic                                  dsync,
    output logic                                  M_AXIS_TVALID,
    output logic                                  M_AXIS_TLAST,
    output logic [8*C_M_AXIS_TDATA_NUM_BYTES-1:0] M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_NUM_BYTES-1:0]   M_AXIS_TKEEP,
    input  logic                                  M_AXIS_TREADY,
    input  logic [31:0]                           ctrl,
    input  logic [31:0]                           pkt_bytes,
    input  logic [15:0]                           pkt_count,
    input  logic                                  trig,
    output logic                                  ovf,
    output logic [31:0]                           stat
);

    localparam int NB         = C_M_AXIS_TDATA_NUM_BYTES;
    localparam int DW         = 8 * NB;
    localparam int BEAT_SHIFT = $clog2(NB);
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    state_t        state_reg, state_next;
    logic          arm, abort, finish;

    logic          enable, ovf_clr, sample;
    logic          enable_prev_reg, trig_prev_reg;
    logic          enable_rise, trig_rise;

    logic          trig_mode_reg, continuous_reg;
    logic [15:0]   pkt_count_reg;
    logic [31:0]   bpp_reg, bpp_arm;
    logic [31:0]   beat_cnt_reg;
    logic [15:0]   pkt_cnt_reg;

    logic          capture_wr, beat_last, pkt_final, drop;

    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [DW:0]   fifo_rd_data;
    logic          out_valid, out_fire, out_last, abort_tail;

    logic [15:0]   ovf_cnt_reg;
    logic [11:0]   pkt_done_cnt_reg;
    logic          aborted_reg, ovf_sticky_reg, done_reg, ovf_reg, busy;

    logic          unused_ctrl;
    assign unused_ctrl = ^ctrl[31:4];

    assign enable      = ctrl[CTRL_ENABLE];
    assign ovf_clr     = ctrl[CTRL_OVF_CLR];
    assign sample      = dvalid & dsync;
    assign enable_rise = enable & ~enable_prev_reg;
    assign trig_rise   = trig & ~trig_prev_reg;

    // Beats per packet from the byte length, sub-beat bytes dropped, never 0.
    always_comb begin
        bpp_arm = pkt_bytes >> BEAT_SHIFT;
        if (bpp_arm == 32'd0) begin
            bpp_arm = 32'd1;
        end
    end

    // Samples are taken only while capturing and still enabled; the cycle in
    // which enable falls is the abort cycle and writes nothing.
    assign capture_wr = (state_reg == ST_CAPTURE) & enable & sample;
    assign beat_last  = (beat_cnt_reg == bpp_reg - 32'd1);
    assign pkt_final  = capture_wr & beat_last & ~continuous_reg &
                        (pkt_count_reg != 16'd0) &
                        ((pkt_cnt_reg + 16'd1) == pkt_count_reg);

    assign out_valid = ~fifo_empty;
    assign out_fire  = out_valid & M_AXIS_TREADY;
    // A write into a full FIFO is lost unless a beat leaves in the same cycle.
    assign drop      = capture_wr & fifo_full & ~out_fire;

    // After an abort the last beat still in the FIFO closes the packet.
    assign abort_tail = (((state_reg == ST_CAPTURE) || (state_reg == ST_ARMED)) && !enable) ||
                        ((state_reg == ST_DRAIN) && aborted_reg);
    assign out_last   = fifo_rd_data[DW] | (abort_tail & (fifo_count == CW'(1)));

    adi2axis_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (AXIS_ACLK),
        .rst_n   (AXIS_ARESETN),
        .wr_en   (capture_wr),
        .wr_data ({beat_last, ddata}),
        .rd_en   (M_AXIS_TREADY),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign M_AXIS_TVALID = out_valid;
    assign M_AXIS_TDATA  = fifo_rd_data[DW-1:0];
    assign M_AXIS_TLAST  = out_valid & out_last;

    for (genvar gi = 0; gi < NB; gi++) begin : g_keep
        assign M_AXIS_TKEEP[gi] = out_valid;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        arm        = 1'b0;
        abort      = 1'b0;
        finish     = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (enable_rise) begin
                    state_next = ST_ARMED;
                    arm        = 1'b1;
                end
            end
            ST_ARMED: begin
                if (!enable) begin
                    state_next = ST_DRAIN;
                    abort      = 1'b1;
                end else if (!trig_mode_reg || trig_rise) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!enable) begin
                    state_next = ST_DRAIN;
                    abort      = 1'b1;
                end else if (pkt_final) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_next = ST_DONE;
                    finish     = 1'b1;
                end
            end
            ST_DONE: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_reg == ST_ARMED) || (state_reg == ST_CAPTURE) ||
                  (state_reg == ST_DRAIN);

    // ---------------- run configuration and framing counters ----------------
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            enable_prev_reg  <= 1'b0;
            trig_prev_reg    <= 1'b0;
            trig_mode_reg    <= 1'b0;
            continuous_reg   <= 1'b0;
            pkt_count_reg    <= '0;
            bpp_reg          <= 32'd1;
            beat_cnt_reg     <= '0;
            pkt_cnt_reg      <= '0;
            pkt_done_cnt_reg <= '0;
            done_reg         <= 1'b0;
            aborted_reg      <= 1'b0;
        end else begin
            enable_prev_reg <= enable;
            trig_prev_reg   <= trig;

            if (arm) begin
                trig_mode_reg    <= ctrl[CTRL_TRIG_MODE];
                continuous_reg   <= ctrl[CTRL_CONTINUOUS];
                pkt_count_reg    <= pkt_count;
                bpp_reg          <= bpp_arm;
                beat_cnt_reg     <= '0;
                pkt_cnt_reg      <= '0;
                pkt_done_cnt_reg <= '0;
                done_reg         <= 1'b0;
                aborted_reg      <= 1'b0;
            end else begin
                // Dropped samples advance framing too, keeping it time-aligned.
                if (capture_wr) begin
                    if (beat_last) begin
                        beat_cnt_reg <= '0;
                        pkt_cnt_reg  <= pkt_cnt_reg + 16'd1;
                    end else begin
                        beat_cnt_reg <= beat_cnt_reg + 32'd1;
                    end
                end
                if (out_fire && out_last) begin
                    pkt_done_cnt_reg <= pkt_done_cnt_reg + 12'd1;
                end
                if (abort) begin
                    aborted_reg <= 1'b1;
                end
                if (finish) begin
                    done_reg <= 1'b1;
                end
            end
        end
    end

    // ---------------- overflow accounting ----------------
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            ovf_reg        <= 1'b0;
            ovf_sticky_reg <= 1'b0;
            ovf_cnt_reg    <= '0;
        end else begin
            ovf_reg <= drop;
            // Clear has priority over a simultaneous drop.
            if (ovf_clr) begin
                ovf_sticky_reg <= 1'b0;
                ovf_cnt_reg    <= '0;
            end else if (drop) begin
                ovf_sticky_reg <= 1'b1;
                if (ovf_cnt_reg != OVF_CNT_MAX) begin
                    ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
                end
            end
        end
    end

    assign ovf = ovf_reg;

    always_comb begin
        stat                          = '0;
        stat[STAT_OVF_CNT +: 16]      = ovf_cnt_reg;
        stat[STAT_PKT_DONE +: 12]     = pkt_done_cnt_reg;
        stat[STAT_ABORTED]            = aborted_reg;
        stat[STAT_OVF_STICKY]         = ovf_sticky_reg;
        stat[STAT_DONE]               = done_reg;
        stat[STAT_BUSY]               = busy;
    end

endmodule
